// File: rtl/sram_fifo_ctrl_8x36_if.sv
// Handshake and SRAM-port bundle for sram_fifo_ctrl_8x36.
//   enq_*      : producer side (valid/ready/bits)
//   deq_*      : consumer side (valid/ready/bits)
//   occupancy  : total entries held by the controller
//   mem_*      : single-port SRAM macro (addr/en/wmode/wdata out, rdata in)
// The slave modport is the controller's view; master is the environment's.
interface sram_fifo_ctrl_8x36_if #(
    parameter int WIDTH  = 36,
    parameter int ADDR_W = 3
);
    logic              enq_valid;
    logic              enq_ready;
    logic [WIDTH-1:0]  enq_bits;
    logic              deq_valid;
    logic              deq_ready;
    logic [WIDTH-1:0]  deq_bits;
    logic [3:0]        occupancy;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_en;
    logic              mem_wmode;
    logic [WIDTH-1:0]  mem_wdata;
    logic [WIDTH-1:0]  mem_rdata;

    modport slave (
        input  enq_valid, enq_bits, deq_ready, mem_rdata,
        output enq_ready, deq_valid, deq_bits, occupancy,
               mem_addr, mem_en, mem_wmode, mem_wdata
    );

    modport master (
        output enq_valid, enq_bits, deq_ready, mem_rdata,
        input  enq_ready, deq_valid, deq_bits, occupancy,
               mem_addr, mem_en, mem_wmode, mem_wdata
    );
endinterface

// File: rtl/sram_fifo_ctrl_8x36.sv
// FIFO controller backed by one single-port 8x36 SRAM (read latency 1).
// The RW port is shared between enqueue writes and prefetch reads (reads
// win); prefetched words land in a 2-entry output buffer that absorbs the
// read latency and consumer backpressure.
// Ports:
//   clock   : single clock (also the macro clock)
//   reset_n : asynchronous active-low reset
//   flush   : synchronous clear of all FIFO state
//   bus     : enq/deq handshakes, occupancy and SRAM port (slave modport)
module sram_fifo_ctrl_8x36 #(
    parameter int WIDTH  = 36,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   flush,
    sram_fifo_ctrl_8x36_if.slave   bus
);
    localparam logic [ADDR_W:0] FULL = ADDR_W'(0) + (ADDR_W+1)'(DEPTH);

    logic [ADDR_W-1:0]       wptr, rptr;
    logic [ADDR_W:0]         scnt;
    logic                    inflight;
    logic [1:0][WIDTH-1:0]   obuf;      // obuf[0] is the head
    logic [1:0]              ocnt;

    logic rd, wr, pop;

    always_comb begin
        // Prefetch only while the staging buffer has room for the word
        // already on its way plus the one about to be requested.
        rd = (scnt != '0) && (({1'b0, ocnt} + {2'b0, inflight}) < 3'd2) && !flush;
        bus.enq_ready = reset_n && !flush && !rd && (scnt != FULL);
        wr  = bus.enq_valid && bus.enq_ready;

        bus.mem_en    = rd || wr;
        bus.mem_wmode = wr;
        bus.mem_addr  = rd ? rptr : wptr;
        bus.mem_wdata = bus.enq_bits;

        bus.deq_valid = (ocnt != 2'd0);
        bus.deq_bits  = obuf[0];
        pop           = bus.deq_valid && bus.deq_ready;

        // The in-flight read is still counted, so a read issue is neutral.
        bus.occupancy = 4'(scnt) + 4'(inflight) + 4'(ocnt);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wptr     <= '0;
            rptr     <= '0;
            scnt     <= '0;
            inflight <= 1'b0;
            obuf     <= '0;
            ocnt     <= 2'd0;
        end else if (flush) begin
            // Any read data returning this cycle is dropped with the rest.
            wptr     <= '0;
            rptr     <= '0;
            scnt     <= '0;
            inflight <= 1'b0;
            obuf     <= '0;
            ocnt     <= 2'd0;
        end else begin
            if (rd) rptr <= rptr + 1'b1;
            if (wr) wptr <= wptr + 1'b1;

            case ({rd, wr})
                2'b10:   scnt <= scnt - 1'b1;
                2'b01:   scnt <= scnt + 1'b1;
                default: ;
            endcase

            inflight <= rd;

            // A push only happens with ocnt<=1 (rd guarantees room), so the
            // push-only case never overruns the two slots.
            case ({inflight, pop})
                2'b10: begin
                    obuf[ocnt[0]] <= bus.mem_rdata;
                    ocnt          <= ocnt + 2'd1;
                end
                2'b01: begin
                    obuf[0] <= obuf[1];
                    ocnt    <= ocnt - 2'd1;
                end
                2'b11: begin
                    if (ocnt == 2'd2) begin
                        obuf[0] <= obuf[1];
                        obuf[1] <= bus.mem_rdata;
                    end else begin
                        obuf[0] <= bus.mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_fifo_ctrl_8x36.sv
// Scoreboard bench for sram_fifo_ctrl_8x36 with a behavioural SRAM macro.
module tb_sram_fifo_ctrl_8x36;
    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    logic flush   = 1'b0;

    sram_fifo_ctrl_8x36_if bus();

    sram_fifo_ctrl_8x36 dut (
        .clock   (clock),
        .reset_n (reset_n),
        .flush   (flush),
        .bus     (bus.slave)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Single-port macro: data only valid the cycle after a read, garbage otherwise.
    logic [35:0] mem [8];
    always @(posedge clock) begin
        if (bus.mem_en && bus.mem_wmode) mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_en && !bus.mem_wmode) bus.mem_rdata <= mem[bus.mem_addr];
        else bus.mem_rdata <= {4'($urandom), 32'($urandom)};
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference model: the FIFO is just an ordered queue of accepted words;
    // its length is the occupancy and the write slot is (accepts mod 8).
    logic [35:0] q[$];
    int wcount   = 0;
    int wait_run = 0;

    always @(negedge clock) begin
        if (reset_n) begin
            automatic bit efire = bus.enq_valid && bus.enq_ready;
            automatic bit dfire = bus.deq_valid && bus.deq_ready;
            chk("occupancy", 64'(bus.occupancy), 64'(q.size()));
            chk("wr_iff_enq", 64'(bus.mem_en && bus.mem_wmode), 64'(efire));
            if (bus.mem_en && !bus.mem_wmode) chk("rd_blocks_enq", 64'(bus.enq_ready), 64'd0);
            if (flush) chk("flush_quiet", {62'd0, bus.enq_ready, bus.mem_en}, 64'd0);
            if (efire) begin
                chk("wr_addr", 64'(bus.mem_addr), 64'(wcount % 8));
                chk("wr_data", 64'(bus.mem_wdata), 64'(bus.enq_bits));
            end
            if (bus.enq_valid && !bus.enq_ready && !flush && q.size() < 8) begin
                wait_run++;
                if (wait_run > 2) chk("enq_wait_bound", 64'(wait_run), 64'd2);
            end else begin
                wait_run = 0;
            end
            if (dfire && !flush) begin
                if (q.size() == 0) chk("deq_unexpected", 64'(bus.deq_bits), 64'd0 - 64'd1);
                else chk("deq_data", 64'(bus.deq_bits), 64'(q.pop_front()));
            end
            if (flush) begin
                q.delete();
                wcount = 0;
            end else if (efire) begin
                q.push_back(bus.enq_bits);
                wcount++;
            end
        end
    end

    // Call from a "posedge + 1" point.
    task automatic drain();
        int n = 0;
        bus.enq_valid = 1'b0;
        bus.deq_ready = 1'b1;
        while (q.size() != 0 && n < 200) begin
            @(posedge clock); #1;
            n++;
        end
        chk("drain_done", 64'(q.size()), 64'd0);
        bus.deq_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, v, n;
        bit found;
        bus.enq_valid = 1'b0;
        bus.enq_bits  = '0;
        bus.deq_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clock);
        chk("rst_enq_ready", 64'(bus.enq_ready), 64'd0);
        chk("rst_deq_valid", 64'(bus.deq_valid), 64'd0);
        chk("rst_mem_en", 64'(bus.mem_en), 64'd0);
        chk("rst_occupancy", 64'(bus.occupancy), 64'd0);
        chk("rst_deq_bits", 64'(bus.deq_bits), 64'd0);
        @(posedge clock); #1 reset_n = 1'b1;

        // Single-entry latency
        @(negedge clock);
        chk("idle_enq_ready", 64'(bus.enq_ready), 64'd1);
        @(posedge clock); #1;
        bus.enq_valid = 1'b1;
        bus.enq_bits  = 36'h123456789;
        @(negedge clock);
        chk("lat_n_wr", {61'd0, bus.mem_en, bus.mem_wmode, bus.mem_addr == 3'd0}, 64'h7);
        @(posedge clock); #1 bus.enq_valid = 1'b0;
        @(negedge clock);
        chk("lat_n1_rd", {61'd0, bus.mem_en, bus.mem_wmode, bus.mem_addr == 3'd0}, 64'h5);
        chk("lat_n1_occ", 64'(bus.occupancy), 64'd1);
        chk("lat_n1_deq_valid", 64'(bus.deq_valid), 64'd0);
        @(negedge clock);
        chk("lat_n2_deq_valid", 64'(bus.deq_valid), 64'd0);
        chk("lat_n2_occ", 64'(bus.occupancy), 64'd1);
        @(negedge clock);
        chk("lat_n3_deq_valid", 64'(bus.deq_valid), 64'd1);
        chk("lat_n3_deq_bits", 64'(bus.deq_bits), 64'h123456789);
        @(posedge clock); #1;
        drain();

        // Fill against backpressure: capacity is exactly 10
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock); #1;
            bus.enq_valid = 1'b1;
            bus.enq_bits  = {4'($urandom), 32'($urandom)};
            @(negedge clock);
            if (bus.enq_ready) acc++;
        end
        chk("full_accepts", 64'(acc), 64'd10);
        chk("full_enq_ready", 64'(bus.enq_ready), 64'd0);
        chk("full_occupancy", 64'(bus.occupancy), 64'd10);
        chk("full_mem_idle", 64'(bus.mem_en), 64'd0);
        chk("full_deq_valid", 64'(bus.deq_valid), 64'd1);
        @(posedge clock); #1;
        drain();

        // Ordered values 0..19 across pointer wrap, random backpressure
        v = 0; n = 0;
        while (v < 20 && n < 500) begin
            @(posedge clock); #1;
            bus.enq_valid = 1'b1;
            bus.enq_bits  = 36'(v);
            bus.deq_ready = 1'($urandom % 2);
            @(negedge clock);
            if (bus.enq_ready) v++;
            n++;
        end
        chk("seq_accepted", 64'(v), 64'd20);
        @(posedge clock); #1;
        drain();

        // Flush with a read in flight
        for (int i = 0; i < 12; i++) begin
            @(posedge clock); #1;
            bus.enq_valid = 1'b1;
            bus.enq_bits  = {4'($urandom), 32'($urandom)};
            @(negedge clock);
        end
        found = 1'b0; n = 0;
        while (!found && n < 100) begin
            @(posedge clock); #1;
            bus.enq_valid = 1'b0;
            bus.deq_ready = 1'($urandom % 2);
            @(negedge clock);
            if (bus.mem_en && !bus.mem_wmode && bus.occupancy >= 4 && bus.occupancy <= 7) found = 1'b1;
            n++;
        end
        chk("flush_setup", 64'(found), 64'd1);
        @(posedge clock); #1;
        flush = 1'b1;
        bus.deq_ready = 1'b1;
        @(negedge clock);
        chk("flush_enq_ready", 64'(bus.enq_ready), 64'd0);
        @(posedge clock); #1;
        flush = 1'b0;
        bus.deq_ready = 1'b0;
        bus.enq_valid = 1'b1;
        bus.enq_bits  = 36'hABCDE1234;
        @(negedge clock);
        chk("post_flush_occ", 64'(bus.occupancy), 64'd0);
        chk("post_flush_deq_valid", 64'(bus.deq_valid), 64'd0);
        chk("post_flush_enq_ready", 64'(bus.enq_ready), 64'd1);
        @(posedge clock); #1;
        drain();

        // Reset mid-burst
        for (int i = 0; i < 7; i++) begin
            @(posedge clock); #1;
            bus.enq_valid = 1'b1;
            bus.enq_bits  = {4'($urandom), 32'($urandom)};
            bus.deq_ready = 1'b0;
            @(negedge clock);
        end
        @(posedge clock); #3;
        reset_n = 1'b0;
        #1;
        chk("arst_enq_ready", 64'(bus.enq_ready), 64'd0);
        chk("arst_deq_valid", 64'(bus.deq_valid), 64'd0);
        chk("arst_mem_en", 64'(bus.mem_en), 64'd0);
        chk("arst_occupancy", 64'(bus.occupancy), 64'd0);
        chk("arst_deq_bits", 64'(bus.deq_bits), 64'd0);
        q.delete();
        wcount = 0;
        bus.enq_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        @(negedge clock);
        chk("rel_enq_ready", 64'(bus.enq_ready), 64'd1);
        @(posedge clock); #1;
        bus.enq_valid = 1'b1;
        bus.enq_bits  = 36'h0F0F0F0F5;
        @(negedge clock);
        chk("rel_wr_addr0", {62'd0, bus.mem_wmode, bus.mem_addr == 3'd0}, 64'h3);
        @(posedge clock); #1;
        drain();

        // Random traffic with occasional flushes
        for (int i = 0; i < 400; i++) begin
            @(posedge clock); #1;
            bus.enq_valid = 1'($urandom % 3 != 0);
            bus.enq_bits  = {4'($urandom), 32'($urandom)};
            bus.deq_ready = 1'($urandom % 2);
            flush = ($urandom % 50 == 0);
            @(negedge clock);
        end
        @(posedge clock); #1;
        flush = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sram_fifo_ctrl_8x36.md
Name: sram_fifo_ctrl_8x36

Overview:
- Synchronous FIFO controller that uses one single-port 8x36 SRAM macro as its backing store.
- The SRAM has one RW port, read latency 1, and read data valid only in the cycle after a read enable.
- Arbitrates the single RW port between enqueue writes and prefetch reads.
- Feeds a 2-entry output staging buffer that absorbs the read latency and consumer backpressure. Sits directly upstream of the macro and drives all of its port signals.

Parameters:
- WIDTH, 36, data width; fixed to match the macro.
- DEPTH, 8, SRAM entries; fixed to match the macro.
- ADDR_W, 3, SRAM address width, log2(DEPTH).

Ports:
- clock  in  1  single clock; also drives the macro clock.
- reset_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of all FIFO state.
- enq_valid  in  1  producer has data.
- enq_ready  out  1  controller accepts enq_bits this cycle.
- enq_bits  in  36  write data.
- deq_valid  out  1  deq_bits valid.
- deq_ready  in  1  consumer takes deq_bits.
- deq_bits  out  36  head entry of the FIFO.
- occupancy  out  4  total entries held (SRAM + staging), 0..10.
- mem_addr  out  3  to macro address.
- mem_en  out  1  to macro enable.
- mem_wmode  out  1  to macro: 1 = write, 0 = read.
- mem_wdata  out  36  to macro write data; always equals enq_bits.
- mem_rdata  in  36  from macro; meaningful only in the cycle after a read issue.

Behaviour:
- State:
  - wptr, rptr: 3-bit, wrap 7->0.
  - scnt: SRAM entries, 0..8.
  - inflight: 1 bit; a read was issued last cycle.
  - obuf: 2 entries, 36 bit, with ocnt 0..2.
- Reset (async, reset_n=0): clear all state; SRAM contents are not touched.
  - Outputs while in reset: enq_ready=0, deq_valid=0, mem_en=0, occupancy=0, deq_bits=0.
  - Effect is immediate, including mid-transfer; any in-flight read is discarded.
- Read issue: rd = (scnt!=0) && (ocnt + inflight < 2) && !flush.
  - Drives mem_en=1, mem_wmode=0, mem_addr=rptr.
  - Next edge: rptr++, scnt--, inflight=1.
- Write:
  - enq_ready = reset_n && !flush && !rd && scnt!=8.
  - On enq fire: mem_en=1, mem_wmode=1, mem_addr=wptr. Next edge: wptr++, scnt++.
- Port priority: read before write. At most one SRAM op per cycle. A write and a read never coincide.
- Idle: when neither a read nor a write issues, mem_en=0, mem_wmode=0, mem_addr=wptr.
- Capture: if inflight, push mem_rdata into obuf at the edge ending that cycle, and clear inflight unless a new rd was issued.
- Dequeue:
  - deq_valid = ocnt!=0; deq_bits = obuf head.
  - Pop on deq_valid && deq_ready.
  - Push and pop in the same cycle are legal; ocnt is unchanged.
- Occupancy: scnt + inflight + ocnt.
  - Enq fire increments it. The in-flight read is counted, so a read issue does not change it. Deq fire decrements it.
- Latency: enq fire in cycle N into an empty FIFO gives a read issued in N+1, rdata present in N+2, and deq_valid=1 in N+3.
- Throughput: single port, so sustained enq+deq is at most 1 op per cycle on the port (~0.5 entry/cycle each direction). A burst of enqueues at 1/cycle is accepted while rd=0.
- Starvation bound: reads stop once obuf plus inflight reach 2 or the SRAM is empty. Writes therefore never wait more than 2 consecutive cycles while scnt<8.
- Full: scnt==8 gives enq_ready=0. Total capacity is 10 (8 in SRAM + 2 in obuf).
- Empty: scnt==0 gives no read issue. Pointers wrap freely; ordering is strictly FIFO across wrap.
- Flush:
  - In the flush cycle: enq_ready=0, rd=0, mem_en=0; deq_valid still reflects state and a deq fire is permitted but its data is discarded.
  - Next edge: all pointers, counts, inflight and obuf are cleared. Any mem_rdata arriving that cycle is dropped.

Test Plan:
- Reset then single enq of 0x123456789 at cycle N -> mem write addr 0 in N; read addr 0 in N+1; deq_valid=1 with deq_bits=0x123456789 in N+3; occupancy 1 from N+1 until deq.
- Hold deq_ready=0 and enq continuously -> exactly 10 accepts; then enq_ready=0 with scnt=8, ocnt=2, occupancy=10; no mem_en while full and blocked.
- 20 sequential enq values 0..19 with random deq_ready -> deq order 0..19 exact; pointer wrap exercised; mem_en never asserts write and read in the same cycle.
- SRAM holding 3 entries, obuf empty, enq_valid held -> reads win the first 2 cycles (enq_ready=0), then the write is accepted in the 3rd cycle.
- Assert flush with inflight=1 and occupancy 5 -> next cycle occupancy=0, deq_valid=0; stale mem_rdata is not captured; the next enq value appears first at deq.
- Drop reset_n mid-burst -> all outputs zero immediately; after release enq_ready=1; first new enq writes addr 0 and comes out correctly.
